bloom_insert: RTL and testbench
===============================

BLOOM_INSERT -- requirements
Module: bloom_insert

Interface
REQ-001 Parameter D_SIZE, default 8, SHALL set the width of each inserted data word.
REQ-002 Parameter BL_SIZE, default 16, SHALL set the width of the Bloom filter; it must be a power of two >= 4.
REQ-003 Parameter K_HASH, default 3, SHALL set the number of hash functions applied per insertion (1..8).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 ins_valid  in  1  insertion request qualifying ins_data.
REQ-007 ins_data  in  D_SIZE  data word to insert.
REQ-008 ins_ready  out  1  high only in IDLE; accept occurs on a rising edge with ins_valid && ins_ready && !clear.
REQ-009 clear  in  1  synchronous filter clear / abort.
REQ-010 gen_bloom  out  BL_SIZE  bit pattern of the most recent (or in-progress) insertion, for the membership comparator.
REQ-011 bloom_filter  out  BL_SIZE  accumulated filter (OR of all gen_bloom since last clear).
REQ-012 done  out  1  one-cycle pulse when an insertion completes.
REQ-013 ins_count  out  8  number of completed insertions since clear, saturating at 255.
REQ-014 filter_full  out  1  registered; high when every bloom_filter bit is 1.

Function
REQ-015 AW = log2(BL_SIZE); hash index h_i(d) SHALL be the low AW bits of (rotate_right(d, 2*i mod D_SIZE) XOR i), i = 0..K_HASH-1, computed at D_SIZE width.
REQ-016 FSM states: IDLE, HASH, DONE.
REQ-017 IDLE: on accept, capture ins_data into an internal register, clear gen_bloom to 0, set hash index counter to 0, go to HASH.
REQ-018 HASH: each cycle set bit h_i of gen_bloom and of bloom_filter, i = counter; after i = K_HASH-1, go to DONE; otherwise increment counter.
REQ-019 DONE: assert done for exactly this cycle, increment ins_count (saturating), go to IDLE.
REQ-020 Latency: done is high exactly K_HASH+1 cycles after the accepting edge; the next accept is possible one cycle after done.
REQ-021 Duplicate hash indices SHALL set the bit once; there is no error.
REQ-022 clear in any state SHALL on the next edge zero bloom_filter, gen_bloom and ins_count, abort any insertion without asserting done, and go to IDLE.
REQ-023 clear and ins_valid in the same cycle: clear wins, no accept.
REQ-024 ins_data changes while not in IDLE SHALL be ignored.
REQ-025 All outputs are registered or derived from registered state; they change only on rising edges, so a consumer sampling on the falling edge sees stable values.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, counter 0, gen_bloom 0, bloom_filter 0, ins_count 0, done 0, filter_full 0; ins_ready is 1 while in IDLE.
REQ-027 Reset asserted mid-insertion SHALL discard the insertion with no done pulse.

Structure
REQ-028 A shared package bloom_pkg SHALL hold the D_SIZE/BL_SIZE/K_HASH defaults, the AW calculation, and the FSM state enumeration.
REQ-029 The hash index SHALL be computed in one combinational sub-module, bloom_hash (inputs data and i; output AW-bit index), reused by the checker side.

Verification
REQ-030 Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately and ins_ready=1 after release.
REQ-031 Insert 8'hA5 -> gen_bloom=16'h0120, bloom_filter=16'h0120, done 4 cycles after accept, ins_count=1 (duplicate index 8 covered).
REQ-032 Then insert 8'h00 -> gen_bloom=16'h0007, bloom_filter=16'h0127, ins_count=2.
REQ-033 Assert clear during the second HASH cycle -> next edge bloom_filter=0, ins_count=0, no done, IDLE; clear+ins_valid together in IDLE -> no accept.
REQ-034 Insert values until all 16 bits are set -> filter_full=1 the cycle after the last bit sets; 300 insertions -> ins_count holds 255.
REQ-035 Hold ins_valid high continuously, changing ins_data each cycle -> accepts only in IDLE, one per K_HASH+2 cycles, and each gen_bloom matches the captured word.

Source files
------------

// File: rtl/bloom_pkg.sv
// bloom_pkg: shared parameter defaults, index-width helper and FSM states for the Bloom inserter.
package bloom_pkg;
  localparam int D_SIZE_DEF = 8;
  localparam int BL_SIZE_DEF = 16;
  localparam int K_HASH_DEF = 3;
  typedef enum logic [1:0] {IDLE, HASH, DONE} state_t;
  function automatic int aw_of(input int bl);
    return $clog2(bl);
  endfunction
endpackage

// File: rtl/bloom_hash.sv
// bloom_hash: combinational hash index, low AW bits of (rotate_right(data, 2*i mod D_SIZE) ^ i).
module bloom_hash import bloom_pkg::*; #(
  parameter int D_SIZE = D_SIZE_DEF,
  parameter int AW = aw_of(BL_SIZE_DEF)
)(
  input  logic [D_SIZE-1:0] data,
  input  logic [2:0]        i,
  output logic [AW-1:0]     idx
);
  // shifting the doubled word right yields the rotation in its low half
  assign idx = AW'(D_SIZE'({data, data} >> ((2 * int'(i)) % D_SIZE)) ^ D_SIZE'(i));
endmodule

// File: rtl/bloom_insert.sv
// bloom_insert: sequential Bloom filter insertion, one hash bit per cycle, with clear and stats.
module bloom_insert import bloom_pkg::*; #(
  parameter int D_SIZE = D_SIZE_DEF,
  parameter int BL_SIZE = BL_SIZE_DEF,
  parameter int K_HASH = K_HASH_DEF
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ins_valid,
  input  logic [D_SIZE-1:0]  ins_data,
  output logic               ins_ready,
  input  logic               clear,
  output logic [BL_SIZE-1:0] gen_bloom,
  output logic [BL_SIZE-1:0] bloom_filter,
  output logic               done,
  output logic [7:0]         ins_count,
  output logic               filter_full
);
  localparam int AW = aw_of(BL_SIZE);
  state_t state, state_nx;
  logic [2:0] cnt;
  logic [D_SIZE-1:0] data;
  logic [AW-1:0] idx;
  logic [BL_SIZE-1:0] hit;
  logic accept;
  assign accept = ins_valid && ins_ready && !clear;
  assign hit = BL_SIZE'(1) << idx;
  bloom_hash #(.D_SIZE(D_SIZE), .AW(AW)) u_hash (.data(data), .i(cnt), .idx(idx));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = clear ? IDLE
             : state == IDLE ? (accept ? HASH : IDLE)
             : state == HASH ? (cnt == 3'(K_HASH - 1) ? DONE : HASH)
             : IDLE;
  end
  always_comb ins_ready = state == IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      data <= '0;
      gen_bloom <= '0;
      bloom_filter <= '0;
      done <= 1'b0;
      ins_count <= '0;
      filter_full <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      gen_bloom <= '0;
      bloom_filter <= '0;
      done <= 1'b0;
      ins_count <= '0;
      filter_full <= 1'b0;
    end else begin
      done <= state == DONE;
      filter_full <= &bloom_filter;
      if (accept) begin
        data <= ins_data;
        gen_bloom <= '0;
        cnt <= '0;
      end
      if (state == HASH) begin
        gen_bloom <= gen_bloom | hit;
        bloom_filter <= bloom_filter | hit;
        cnt <= cnt + 3'd1;
      end
      if (state == DONE && ins_count != 8'hFF) ins_count <= ins_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_bloom_insert.sv
// tb_bloom_insert: randomized self-checking bench against an arithmetic Bloom filter model.
module tb_bloom_insert;
  localparam int K = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ins_valid = 1'b0;
  logic [7:0] ins_data = '0;
  logic clear = 1'b0;
  logic ins_ready, done, filter_full;
  logic [15:0] gen_bloom, bloom_filter;
  logic [7:0] ins_count;
  int passed = 0;
  int total = 0;
  logic [15:0] m_filter = '0;
  int m_count = 0;

  bloom_insert dut (
    .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins_data(ins_data),
    .ins_ready(ins_ready), .clear(clear), .gen_bloom(gen_bloom),
    .bloom_filter(bloom_filter), .done(done), .ins_count(ins_count),
    .filter_full(filter_full)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pattern(input logic [7:0] d);
    logic [15:0] p = '0;
    for (int i = 0; i < K; i++) begin
      int r = (2 * i) % 8;
      logic [7:0] rr = (d >> r) | (d << (8 - r));
      logic [7:0] v = rr ^ 8'(i);
      p[v[3:0]] = 1'b1;
    end
    return p;
  endfunction

  task automatic model_add(input logic [7:0] d);
    m_filter = m_filter | pattern(d);
    m_count = (m_count < 255) ? m_count + 1 : 255;
  endtask

  task automatic insert(input logic [7:0] d, output int lat);
    @(negedge clk);
    ins_valid = 1'b1;
    ins_data = d;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      ins_valid = 1'b0;
      ins_data = 8'($urandom);
      if (done) begin
        lat = n - 1;
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({gen_bloom, bloom_filter, done, ins_count, filter_full} !== '0) $display("FAIL reset_outputs: got %h/%h/%b/%0d/%b required 0", gen_bloom, bloom_filter, done, ins_count, filter_full);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (ins_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", ins_ready);
    else passed++;
  endtask

  task automatic test_spec_vectors;
    int lat;
    insert(8'hA5, lat);
    model_add(8'hA5);
    total++;
    if (lat !== K + 1) $display("FAIL a5_latency: got %0d required %0d", lat, K + 1);
    else passed++;
    total++;
    if (gen_bloom !== 16'h0120 || bloom_filter !== 16'h0120) $display("FAIL a5_bloom: got gen %h filt %h required 0120 0120", gen_bloom, bloom_filter);
    else passed++;
    total++;
    if (ins_count !== 8'd1) $display("FAIL a5_count: got %0d required 1", ins_count);
    else passed++;
    insert(8'h00, lat);
    model_add(8'h00);
    total++;
    if (gen_bloom !== 16'h0007 || bloom_filter !== 16'h0127 || ins_count !== 8'd2) $display("FAIL zero_insert: got gen %h filt %h cnt %0d required 0007 0127 2", gen_bloom, bloom_filter, ins_count);
    else passed++;
  endtask

  task automatic test_clear_mid_hash;
    int dones = 0;
    @(negedge clk);
    ins_valid = 1'b1;
    ins_data = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    ins_valid = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_filter = '0;
    m_count = 0;
    total++;
    if (bloom_filter !== 16'h0 || gen_bloom !== 16'h0 || ins_count !== 8'd0 || ins_ready !== 1'b1 || done !== 1'b0) $display("FAIL clear_mid_hash: got filt %h gen %h cnt %0d rdy %b done %b required 0 0 0 1 0", bloom_filter, gen_bloom, ins_count, ins_ready, done);
    else passed++;
    repeat (6) begin
      @(negedge clk);
      dones += int'(done);
    end
    total++;
    if (dones !== 0) $display("FAIL clear_no_done: got %0d done pulses required 0", dones);
    else passed++;
  endtask

  task automatic test_clear_with_valid;
    int dones = 0;
    @(negedge clk);
    clear = 1'b1;
    ins_valid = 1'b1;
    ins_data = 8'hFF;
    @(negedge clk);
    clear = 1'b0;
    ins_valid = 1'b0;
    total++;
    if (ins_ready !== 1'b1) $display("FAIL clear_valid_ready: got %b required 1", ins_ready);
    else passed++;
    repeat (6) begin
      @(negedge clk);
      dones += int'(done);
    end
    total++;
    if (dones !== 0 || bloom_filter !== 16'h0) $display("FAIL clear_valid_accept: got %0d dones filt %h required 0 0000", dones, bloom_filter);
    else passed++;
  endtask

  task automatic test_random;
    int lat;
    logic [7:0] d;
    for (int n = 0; n < 20; n++) begin
      d = 8'($urandom);
      insert(d, lat);
      model_add(d);
      total++;
      if (lat !== K + 1 || gen_bloom !== pattern(d) || bloom_filter !== m_filter || ins_count !== 8'(m_count)) $display("FAIL random_insert: d %h got lat %0d gen %h filt %h cnt %0d required %0d %h %h %0d", d, lat, gen_bloom, bloom_filter, ins_count, K + 1, pattern(d), m_filter, m_count);
      else passed++;
    end
  endtask

  task automatic test_full;
    int lat;
    int d = 0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_filter = '0;
    m_count = 0;
    while (m_filter != 16'hFFFF && d < 256) begin
      insert(8'(d), lat);
      model_add(8'(d));
      total++;
      if (filter_full !== (&m_filter) || bloom_filter !== m_filter) $display("FAIL filter_full: d %0d got full %b filt %h required %b %h", d, filter_full, bloom_filter, &m_filter, m_filter);
      else passed++;
      d++;
    end
    total++;
    if (filter_full !== 1'b1) $display("FAIL filter_full_end: got %b required 1", filter_full);
    else passed++;
  endtask

  task automatic test_saturate;
    int lat;
    logic [7:0] d;
    for (int n = 0; n < 300; n++) begin
      d = 8'($urandom);
      insert(d, lat);
      model_add(d);
      if (n == 254 || n == 299) begin
        total++;
        if (ins_count !== 8'(m_count)) $display("FAIL saturate_count: n %0d got %0d required %0d", n, ins_count, m_count);
        else passed++;
      end
    end
    total++;
    if (ins_count !== 8'd255) $display("FAIL saturate_final: got %0d required 255", ins_count);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] cap = '0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_filter = '0;
    m_count = 0;
    ins_valid = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      total++;
      if (ins_ready !== (c % (K + 2) == 0)) $display("FAIL b2b_ready: cycle %0d got %b required %b", c, ins_ready, c % (K + 2) == 0);
      else passed++;
      total++;
      if (done !== (c > 0 && c % (K + 2) == 0)) $display("FAIL b2b_done: cycle %0d got %b required %b", c, done, c > 0 && c % (K + 2) == 0);
      else passed++;
      if (c > 0 && c % (K + 2) == 0) begin
        model_add(cap);
        total++;
        if (gen_bloom !== pattern(cap) || bloom_filter !== m_filter || ins_count !== 8'(m_count)) $display("FAIL b2b_bloom: cycle %0d got gen %h filt %h cnt %0d required %h %h %0d", c, gen_bloom, bloom_filter, ins_count, pattern(cap), m_filter, m_count);
        else passed++;
      end
      ins_data = 8'($urandom);
      if (c == 30) ins_valid = 1'b0;
      else if (c % (K + 2) == 0) cap = ins_data;
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset_mid;
    int dones = 0;
    @(negedge clk);
    ins_valid = 1'b1;
    ins_data = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    ins_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({gen_bloom, bloom_filter, done, ins_count, filter_full} !== '0 || ins_ready !== 1'b1) $display("FAIL async_reset: got %h/%h/%b/%0d/%b rdy %b required 0 rdy 1", gen_bloom, bloom_filter, done, ins_count, filter_full, ins_ready);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      dones += int'(done);
    end
    total++;
    if (dones !== 0 || ins_ready !== 1'b1) $display("FAIL async_reset_abort: got %0d dones rdy %b required 0 1", dones, ins_ready);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_spec_vectors;
    test_clear_mid_hash;
    test_clear_with_valid;
    test_random;
    test_full;
    test_saturate;
    test_back_to_back;
    test_async_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
